// File: rtl/bcd_to_bin_serial_if.sv
// Bus bundle for the serial BCD-to-binary converter.
//
// Handshake: the master raises start with bcd_in valid; the converter
// accepts it on the first rising clk edge where busy is low (start while
// busy is ignored, never queued). done pulses high for exactly one cycle
// when bin/err are valid; bin/err then hold until the next accepted
// conversion completes.
interface bcd_to_bin_serial_if #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [BIN_W-1:0]      bin;

    modport master (output start, bcd_in, input busy, done, err, bin);
    modport slave  (input start, bcd_in, output busy, done, err, bin);
endinterface

// File: rtl/bcd_to_bin_serial.sv
// Sequential BCD-to-binary converter using reverse double-dabble:
// {bcd_reg, work_reg} shifts right one bit per cycle, then every BCD digit
// >= 8 has 3 subtracted. Illegal digits (> 9) abort with err set.
module bcd_to_bin_serial #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    bcd_to_bin_serial_if.slave  bus,
    output logic [1:0]          dbg_state
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [BCD_W-1:0]   bcd_reg, bcd_nxt, bcd_shifted;
    logic [BIN_W-1:0]   work_reg, work_nxt, work_shifted;
    logic [BIN_W-1:0]   bin_reg, bin_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               err_reg, err_nxt;
    logic               bad_pend, bad_pend_nxt;
    logic               illegal;

    // Same nibble-range test as the BCD adder's decimal correction.
    function automatic logic digit_illegal(input logic [3:0] d);
        return (d[3] & d[2]) | (d[3] & d[1]);
    endfunction

    // Flag any illegal digit in the incoming word.
    always_comb begin
        illegal = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            illegal = illegal | digit_illegal(bus.bcd_in[4*i +: 4]);
        end
    end

    // One reverse double-dabble step: shift right, then correct digits >= 8.
    always_comb begin
        work_shifted = {bcd_reg[0], work_reg[BIN_W-1:1]};
        bcd_shifted  = bcd_reg >> 1;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_shifted[4*i+3]) begin
                bcd_shifted[4*i +: 4] = bcd_shifted[4*i +: 4] - 4'd3;
            end
        end
    end

    // Next-state and datapath control. The illegal-digit verdict is latched
    // at acceptance and acted on in the first SHIFT cycle, so an error
    // completes one edge after START without touching the datapath.
    always_comb begin
        state_nxt    = state;
        bcd_nxt      = bcd_reg;
        work_nxt     = work_reg;
        cnt_nxt      = cnt;
        bin_nxt      = bin_reg;
        err_nxt      = err_reg;
        bad_pend_nxt = bad_pend;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    bcd_nxt      = bus.bcd_in;
                    work_nxt     = '0;
                    cnt_nxt      = '0;
                    bad_pend_nxt = illegal;
                    state_nxt    = SHIFT;
                end
            end
            SHIFT: begin
                if (bad_pend) begin
                    bad_pend_nxt = 1'b0;
                    bin_nxt      = '0;
                    err_nxt      = 1'b1;
                    state_nxt    = FINISH;
                end else begin
                    bcd_nxt  = bcd_shifted;
                    work_nxt = work_shifted;
                    cnt_nxt  = cnt + CNT_W'(1);
                    if (cnt == LAST_STEP) begin
                        bin_nxt   = work_shifted;
                        err_nxt   = 1'b0;
                        state_nxt = FINISH;
                    end
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bcd_reg  <= '0;
            work_reg <= '0;
            cnt      <= '0;
            bin_reg  <= '0;
            err_reg  <= 1'b0;
            bad_pend <= 1'b0;
        end else begin
            state    <= state_nxt;
            bcd_reg  <= bcd_nxt;
            work_reg <= work_nxt;
            cnt      <= cnt_nxt;
            bin_reg  <= bin_nxt;
            err_reg  <= err_nxt;
            bad_pend <= bad_pend_nxt;
        end
    end

    // A legal input must leave no residue in the BCD register after the last step.
    always_ff @(posedge clk) begin
        if (rst_n && state == SHIFT && !bad_pend && cnt == LAST_STEP) begin
            assert (bcd_shifted == '0);
        end
    end

    assign bus.busy  = (state != IDLE);
    assign bus.done  = (state == FINISH);
    assign bus.err   = err_reg;
    assign bus.bin   = bin_reg;
    assign dbg_state = state;
endmodule

// File: tb/tb_bcd_to_bin_serial.sv
// Bench for bcd_to_bin_serial: directed cases, a start-while-busy case,
// mid-conversion reset, an exhaustive 000..999 sweep and random words
// including illegal digits, all checked against an arithmetic model.
module tb_bcd_to_bin_serial;
    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;

    logic clk;
    logic rst_n;
    logic [1:0] dbg_state;
    int compared;
    int mismatched;

    bcd_to_bin_serial_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

    bcd_to_bin_serial #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal value of the digits, or 0 with err on any digit > 9.
    task automatic ref_model(input logic [11:0] b, output logic [9:0] v, output logic e);
        int d0, d1, d2;
        d0 = int'(b[3:0]);
        d1 = int'(b[7:4]);
        d2 = int'(b[11:8]);
        e = (d0 > 9) || (d1 > 9) || (d2 > 9);
        v = e ? 10'd0 : 10'(d2 * 100 + d1 * 10 + d0);
    endtask

    // Wait for DONE after an accepted START; returns cycles elapsed and busy count.
    task automatic wait_done(input int start_cyc, output int cyc, output int busy_cnt, output logic got);
        cyc = start_cyc;
        busy_cnt = start_cyc;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (bus.done) begin
                got = 1'b1;
            end else begin
                cyc++;
                if (bus.busy) busy_cnt++;
            end
        end
    endtask

    task automatic do_conv(input logic [11:0] bcd, input string tag);
        int cyc, busy_cnt, exp_lat;
        logic got, exp_err;
        logic [9:0] exp_bin;
        ref_model(bcd, exp_bin, exp_err);
        exp_lat = exp_err ? 1 : BIN_W;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = bcd;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.bcd_in = 12'($urandom);
        wait_done(0, cyc, busy_cnt, got);
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
        check({tag, "_busy_in_done"}, 32'(bus.busy), 32'd1);
        check({tag, "_bin"}, 32'(bus.bin), 32'(exp_bin));
        check({tag, "_err"}, 32'(bus.err), 32'(exp_err));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_bin_hold"}, 32'(bus.bin), 32'(exp_bin));
    endtask

    initial begin
        int cyc, busy_cnt, dones;
        logic got;
        logic [11:0] r;
        compared   = 0;
        mismatched = 0;

        // Reset
        rst_n      = 1'b1;
        bus.start  = 1'b0;
        bus.bcd_in = '0;
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_bin", 32'(bus.bin), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;

        // Directed cases
        do_conv(12'h000, "zero");
        do_conv(12'h999, "c999");
        do_conv(12'h255, "c255");
        do_conv(12'h100, "c100");
        do_conv(12'h1A3, "illegal_1a3");
        do_conv(12'h042, "c042");

        // START during SHIFT is ignored; START held across FINISH restarts
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = 12'h500;
        @(posedge clk);
        cyc = 0;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (bus.done) got = 1'b1;
            else begin
                cyc++;
                if (cyc == 3) bus.bcd_in = 12'h001;
            end
        end
        check("ign_done_seen", 32'(got), 32'd1);
        check("ign_latency", 32'(cyc), 32'(BIN_W));
        check("ign_bin", 32'(bus.bin), 32'd500);
        check("ign_err", 32'(bus.err), 32'd0);
        @(negedge clk);
        check("ign_idle_busy", 32'(bus.busy), 32'd0);
        check("ign_idle_done", 32'(bus.done), 32'd0);
        check("ign_bin_hold", 32'(bus.bin), 32'd500);
        @(negedge clk);
        check("hold_restart_busy", 32'(bus.busy), 32'd1);
        bus.start = 1'b0;
        wait_done(1, cyc, busy_cnt, got);
        check("hold_done_seen", 32'(got), 32'd1);
        check("hold_latency", 32'(cyc), 32'(BIN_W));
        check("hold_bin", 32'(bus.bin), 32'd1);

        // Reset in the middle of a conversion
        do_conv(12'h999, "pre_rst");
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = 12'h777;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_busy_before", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_done", 32'(bus.done), 32'd0);
        check("mid_rst_err", 32'(bus.err), 32'd0);
        check("mid_rst_bin", 32'(bus.bin), 32'd0);
        check("mid_rst_state", 32'(dbg_state), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("mid_rst_no_done", 32'(dones), 32'd0);
        do_conv(12'h777, "after_rst");

        // Exhaustive legal sweep
        for (int i = 0; i < 1000; i++) begin
            r = {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)};
            do_conv(r, "sweep");
        end

        // Random words, illegal digits included, with random idle gaps
        for (int i = 0; i < 150; i++) begin
            r = 12'($urandom);
            do_conv(r, "rand");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
